// File: rtl/data_access_unit_pkg.sv
// Shared definitions for the data access unit: op/mode encodings and FSM states.
package dau_pkg;

  typedef enum logic [2:0] {
    OP_LD   = 3'b000,
    OP_ST   = 3'b001,
    OP_PUSH = 3'b010,
    OP_POP  = 3'b011,
    OP_IN   = 3'b100,
    OP_OUT  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    MODE_PLAIN   = 2'b00,
    MODE_POSTINC = 2'b01,
    MODE_PREDEC  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  // I/O register 0 as seen in the flat data space; debug display only.
  localparam logic [15:0] IO_BASE = 16'h0020;

endpackage

// File: rtl/data_access_unit_if.sv
// Memory-map bus between the data access unit (master) and the data-space map (slave).
interface data_access_unit_if #(parameter int unsigned PTR_W = 16);

  logic [PTR_W-1:0] mem_addr;
  logic             mem_WE;
  logic [7:0]       mem_data;
  logic             mem_IO_only;
  logic [7:0]       mem_Q;

  modport master (output mem_addr, mem_WE, mem_data, mem_IO_only, input mem_Q);
  modport slave  (input mem_addr, mem_WE, mem_data, mem_IO_only, output mem_Q);

endinterface

// File: rtl/data_access_unit_ea_calc.sv
// Combinational effective-address and pointer write-back calculation per access type.
module dau_ea_calc
  import dau_pkg::*;
#(
  parameter int unsigned PTR_W = 16
) (
  input  logic [2:0]       i_op,
  input  logic [1:0]       i_mode,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [5:0]       i_io_addr,
  output logic [PTR_W-1:0] o_ea,
  output logic [PTR_W-1:0] o_ptr_new,
  output logic             o_upd,
  output logic             o_io_only,
  output logic             o_is_write,
  output logic             o_illegal
);

  logic [PTR_W-1:0] w_inc;
  logic [PTR_W-1:0] w_dec;

  assign w_inc = i_ptr + PTR_W'(1);
  assign w_dec = i_ptr - PTR_W'(1);

  always_comb begin
    o_ea       = i_ptr;
    o_ptr_new  = i_ptr;
    o_upd      = 1'b0;
    o_io_only  = 1'b0;
    o_is_write = 1'b0;
    o_illegal  = 1'b0;
    case (op_e'(i_op))
      OP_LD, OP_ST: begin
        o_is_write = (i_op == OP_ST);
        case (mode_e'(i_mode))
          MODE_POSTINC: begin
            o_ptr_new = w_inc;
            o_upd     = 1'b1;
          end
          MODE_PREDEC: begin
            o_ea      = w_dec;
            o_ptr_new = w_dec;
            o_upd     = 1'b1;
          end
          default: ;
        endcase
      end
      OP_PUSH: begin
        o_is_write = 1'b1;
        o_ptr_new  = w_dec;
        o_upd      = 1'b1;
      end
      OP_POP: begin
        o_ea      = w_inc;
        o_ptr_new = w_inc;
        o_upd     = 1'b1;
      end
      OP_IN, OP_OUT: begin
        o_ea       = PTR_W'(i_io_addr);
        o_io_only  = 1'b1;
        o_is_write = (i_op == OP_OUT);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_access_unit.sv
// CPU-side initiator for the data-space memory map: sequences one LD/ST/PUSH/POP/IN/OUT
// access, captures read data and reports the pointer write-back.
module data_access_unit
  import dau_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned PTR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       mode,
  input  logic [PTR_W-1:0] ptr,
  input  logic [5:0]       io_addr,
  input  logic [7:0]       wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       rdata,
  output logic [PTR_W-1:0] ptr_new,
  output logic             ptr_we,
  data_access_unit_if.master mem
);

  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

  state_e           r_state, w_next_state;
  logic [2:0]       r_cnt;
  logic             r_is_write;
  logic             r_upd;
  logic             w_accept, w_finish;

  logic [PTR_W-1:0] w_ea, w_ptr_new;
  logic             w_upd, w_io_only, w_is_write, w_illegal;

  dau_ea_calc #(.PTR_W(PTR_W)) u_ea_calc (
    .i_op       (op),
    .i_mode     (mode),
    .i_ptr      (ptr),
    .i_io_addr  (io_addr),
    .o_ea       (w_ea),
    .o_ptr_new  (w_ptr_new),
    .o_upd      (w_upd),
    .o_io_only  (w_io_only),
    .o_is_write (w_is_write),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_accept     = 1'b1;
        w_next_state = w_illegal ? S_DONE : S_ISSUE;
      end
      S_ISSUE: w_next_state = S_WAIT;
      // r_cnt holds (edges since acceptance - 1), so LAST_CNT marks edge READ_LATENCY
      S_WAIT: if (r_is_write || (r_cnt == LAST_CNT)) begin
        w_finish     = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      rdata           <= '0;
      ptr_new         <= '0;
      ptr_we          <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_WE      <= 1'b0;
      mem.mem_data    <= '0;
      mem.mem_IO_only <= 1'b0;
      r_cnt           <= '0;
      r_is_write      <= 1'b0;
      r_upd           <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      ptr_we <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          busy  <= 1'b1;
          r_cnt <= '0;
          if (w_illegal) begin
            done       <= 1'b1;
            err        <= 1'b1;
            r_upd      <= 1'b0;
            r_is_write <= 1'b0;
          end else begin
            mem.mem_addr    <= w_ea;
            mem.mem_IO_only <= w_io_only;
            mem.mem_WE      <= w_is_write;
            mem.mem_data    <= wdata;
            ptr_new         <= w_ptr_new;
            r_is_write      <= w_is_write;
            r_upd           <= w_upd;
          end
        end
        S_ISSUE: begin
          mem.mem_WE <= 1'b0;
          r_cnt      <= r_cnt + 3'd1;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_finish) begin
            done            <= 1'b1;
            ptr_we          <= r_upd;
            mem.mem_IO_only <= 1'b0;
            if (!r_is_write) rdata <= mem.mem_Q;
          end
        end
        S_DONE:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench for data_access_unit with a two-register-latency memory map model.
module tb_data_access_unit;
  import dau_pkg::*;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  mode = '0;
  logic [15:0] ptr = '0;
  logic [5:0]  io_addr = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, err, ptr_we;
  logic [7:0]  rdata;
  logic [15:0] ptr_new;

  data_access_unit_if #(.PTR_W(16)) mif ();

  data_access_unit #(.READ_LATENCY(RL), .PTR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .mode(mode), .ptr(ptr),
    .io_addr(io_addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .ptr_new(ptr_new), .ptr_we(ptr_we), .mem(mif.master)
  );

  always #5 clk = ~clk;

  // Memory map model: registered write enables, two output registers on read.
  logic [7:0] mem_arr [0:65535];
  logic [7:0] io_arr  [0:63];
  logic [7:0] q1 = '0, q2 = '0;
  always @(posedge clk) begin
    if (mif.mem_WE) begin
      if (mif.mem_IO_only) io_arr[mif.mem_addr[5:0]] <= mif.mem_data;
      else                 mem_arr[mif.mem_addr]     <= mif.mem_data;
    end
    q1 <= mif.mem_IO_only ? io_arr[mif.mem_addr[5:0]] : mem_arr[mif.mem_addr];
    q2 <= q1;
  end
  assign mif.mem_Q = q2;

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] ptr_new;
    logic        ptr_we;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_rd = '0;

  always @(negedge clk) begin
    if (!reset && done) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done=1 required no pending access");
      end else begin
        mon_e = sb_q.pop_front();
        if (rdata !== mon_e.rdata) begin
          n_bad++;
          $display("FAIL sb_rdata: got %h required %h", rdata, mon_e.rdata);
        end
        n_vec++;
        if (ptr_we !== mon_e.ptr_we || err !== mon_e.err || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL sb_flags: got ptr_we=%b err=%b busy=%b required %b %b 1",
                   ptr_we, err, busy, mon_e.ptr_we, mon_e.err);
        end
        if (mon_e.ptr_we) begin
          n_vec++;
          if (ptr_new !== mon_e.ptr_new) begin
            n_bad++;
            $display("FAIL sb_ptr_new: got %h required %h", ptr_new, mon_e.ptr_new);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] rd, input logic [15:0] pn, input logic pwe,
                          input logic er);
    exp_t e;
    e.rdata = rd; e.ptr_new = pn; e.ptr_we = pwe; e.err = er;
    sb_q.push_back(e);
  endtask

  // Returns at the sample point just after the acceptance edge.
  task automatic issue(input logic [2:0] o, input logic [1:0] m, input logic [15:0] p,
                       input logic [5:0] ia, input logic [7:0] wd);
    @(negedge clk);
    op = o; mode = m; ptr = p; io_addr = ia; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: got busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, err, ptr_we, mif.mem_WE, mif.mem_IO_only} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, done, err, ptr_we, mif.mem_WE, mif.mem_IO_only});
    end
    n_vec++;
    if ({rdata, ptr_new, mif.mem_addr, mif.mem_data} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h required 0",
               {rdata, ptr_new, mif.mem_addr, mif.mem_data});
    end
    reset = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_store_load;
    int lat;
    push_exp(last_rd, 16'h0, 1'b0, 1'b0);
    issue(OP_ST, MODE_PLAIN, 16'h0100, 6'h0, 8'hA5);
    n_vec++;
    if ({mif.mem_WE, mif.mem_addr, mif.mem_data, busy} !== {1'b1, 16'h0100, 8'hA5, 1'b1}) begin
      n_bad++;
      $display("FAIL st_strobe: got we=%b addr=%h data=%h busy=%b required 1 0100 a5 1",
               mif.mem_WE, mif.mem_addr, mif.mem_data, busy);
    end
    @(negedge clk);
    n_vec++;
    if ({mif.mem_WE, mif.mem_addr, mif.mem_data} !== {1'b0, 16'h0100, 8'hA5}) begin
      n_bad++;
      $display("FAIL st_strobe_end: got we=%b addr=%h data=%h required 0 0100 a5",
               mif.mem_WE, mif.mem_addr, mif.mem_data);
    end
    wait_done(1, lat);
    n_vec++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL st_latency: got %0d required 2", lat);
    end
    wait_idle("st");
    push_exp(8'hA5, 16'h0, 1'b0, 1'b0);
    last_rd = 8'hA5;
    issue(OP_LD, MODE_PLAIN, 16'h0100, 6'h0, 8'h00);
    n_vec++;
    if ({mif.mem_WE, mif.mem_addr} !== {1'b0, 16'h0100}) begin
      n_bad++;
      $display("FAIL ld_addr: got we=%b addr=%h required 0 0100", mif.mem_WE, mif.mem_addr);
    end
    wait_done(0, lat);
    n_vec++;
    if (lat !== RL) begin
      n_bad++;
      $display("FAIL ld_latency: got %0d required %0d", lat, RL);
    end
    wait_idle("ld");
  endtask

  task automatic test_push_pop;
    int lat;
    push_exp(last_rd, 16'h085E, 1'b1, 1'b0);
    issue(OP_PUSH, MODE_PLAIN, 16'h085F, 6'h0, 8'h3C);
    n_vec++;
    if ({mif.mem_WE, mif.mem_addr, mif.mem_data} !== {1'b1, 16'h085F, 8'h3C}) begin
      n_bad++;
      $display("FAIL push_strobe: got we=%b addr=%h data=%h required 1 085f 3c",
               mif.mem_WE, mif.mem_addr, mif.mem_data);
    end
    wait_done(0, lat);
    wait_idle("push");
    push_exp(8'h3C, 16'h085F, 1'b1, 1'b0);
    last_rd = 8'h3C;
    issue(OP_POP, MODE_PLAIN, 16'h085E, 6'h0, 8'h00);
    n_vec++;
    if ({mif.mem_WE, mif.mem_addr} !== {1'b0, 16'h085F}) begin
      n_bad++;
      $display("FAIL pop_addr: got we=%b addr=%h required 0 085f", mif.mem_WE, mif.mem_addr);
    end
    wait_done(0, lat);
    wait_idle("pop");
  endtask

  task automatic test_wrap;
    int lat;
    // Model preload gives mem[ffff] = ff ^ ff ^ 5a = 5a
    push_exp(8'h5A, 16'hFFFF, 1'b1, 1'b0);
    issue(OP_LD, MODE_PREDEC, 16'h0000, 6'h0, 8'h00);
    n_vec++;
    if (mif.mem_addr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL predec_addr: got %h required ffff", mif.mem_addr);
    end
    wait_done(0, lat);
    wait_idle("predec");
    push_exp(8'h5A, 16'h0000, 1'b1, 1'b0);
    last_rd = 8'h5A;
    issue(OP_LD, MODE_POSTINC, 16'hFFFF, 6'h0, 8'h00);
    n_vec++;
    if (mif.mem_addr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL postinc_addr: got %h required ffff", mif.mem_addr);
    end
    wait_done(0, lat);
    wait_idle("postinc");
  endtask

  task automatic test_io;
    int lat;
    push_exp(last_rd, 16'h0, 1'b0, 1'b0);
    issue(OP_OUT, MODE_PREDEC, 16'h1234, 6'h3D, 8'h5F);
    n_vec++;
    if ({mif.mem_WE, mif.mem_IO_only, mif.mem_addr} !== {1'b1, 1'b1, 16'h003D}) begin
      n_bad++;
      $display("FAIL out_strobe: got we=%b io=%b addr=%h required 1 1 003d",
               mif.mem_WE, mif.mem_IO_only, mif.mem_addr);
    end
    @(negedge clk);
    n_vec++;
    if ({mif.mem_WE, mif.mem_IO_only} !== 2'b01) begin
      n_bad++;
      $display("FAIL out_strobe_end: got we=%b io=%b required 0 1", mif.mem_WE, mif.mem_IO_only);
    end
    wait_done(1, lat);
    n_vec++;
    if (mif.mem_IO_only !== 1'b0) begin
      n_bad++;
      $display("FAIL out_done_io: got %b required 0", mif.mem_IO_only);
    end
    wait_idle("out");
    push_exp(8'h5F, 16'h0, 1'b0, 1'b0);
    last_rd = 8'h5F;
    issue(OP_IN, MODE_POSTINC, 16'h4321, 6'h3D, 8'h00);
    n_vec++;
    if ({mif.mem_WE, mif.mem_IO_only, mif.mem_addr} !== {1'b0, 1'b1, 16'h003D}) begin
      n_bad++;
      $display("FAIL in_addr: got we=%b io=%b addr=%h required 0 1 003d",
               mif.mem_WE, mif.mem_IO_only, mif.mem_addr);
    end
    wait_done(0, lat);
    wait_idle("in");
  endtask

  task automatic test_back_to_back;
    int busy_cnt;
    int dones;
    logic [15:0] addr_before;
    busy_cnt = 0;
    dones = 0;
    push_exp(8'hA5, 16'h0, 1'b0, 1'b0);
    last_rd = 8'hA5;
    @(negedge clk);
    op = OP_LD; mode = MODE_PLAIN; ptr = 16'h0100; io_addr = '0; wdata = '0; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) dones++;
      if (!busy) break;
    end
    start = 1'b0;
    n_vec++;
    if (busy_cnt !== RL + 1 || dones !== 1) begin
      n_bad++;
      $display("FAIL held_start: got busy_cycles=%0d dones=%0d required %0d 1",
               busy_cnt, dones, RL + 1);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_start_requeue: got busy=%b required 0", busy);
    end
    addr_before = mif.mem_addr;
    push_exp(last_rd, 16'h0, 1'b0, 1'b1);
    issue(3'b111, MODE_POSTINC, 16'h2222, 6'h0, 8'hEE);
    n_vec++;
    if ({done, err, mif.mem_WE, mif.mem_addr} !== {1'b1, 1'b1, 1'b0, addr_before}) begin
      n_bad++;
      $display("FAIL illegal: got done=%b err=%b we=%b addr=%h required 1 1 0 %h",
               done, err, mif.mem_WE, mif.mem_addr, addr_before);
    end
    @(negedge clk);
    n_vec++;
    if ({done, err, busy, mif.mem_WE} !== 4'b0) begin
      n_bad++;
      $display("FAIL illegal_end: got done=%b err=%b busy=%b we=%b required 0 0 0 0",
               done, err, busy, mif.mem_WE);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    issue(OP_ST, MODE_PLAIN, 16'h0200, 6'h0, 8'h77);
    n_vec++;
    if (mif.mem_WE !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre: got we=%b required 1", mif.mem_WE);
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if ({mif.mem_WE, busy, done, ptr_we, mif.mem_addr, mif.mem_data, rdata} !== 36'h0) begin
      n_bad++;
      $display("FAIL abort_async: got we=%b busy=%b done=%b ptr_we=%b addr=%h data=%h rdata=%h required all 0",
               mif.mem_WE, busy, done, ptr_we, mif.mem_addr, mif.mem_data, rdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    push_exp(8'h00, 16'h0, 1'b0, 1'b0);
    issue(OP_ST, MODE_PLAIN, 16'h0200, 6'h0, 8'h77);
    wait_done(0, lat);
    wait_idle("post_rst_st");
    push_exp(8'h77, 16'h0, 1'b0, 1'b0);
    last_rd = 8'h77;
    issue(OP_LD, MODE_PLAIN, 16'h0200, 6'h0, 8'h00);
    wait_done(0, lat);
    n_vec++;
    if (lat !== RL) begin
      n_bad++;
      $display("FAIL post_rst_ld_latency: got %0d required %0d", lat, RL);
    end
    wait_idle("post_rst_ld");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem_arr[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    for (int i = 0; i < 64; i++) io_arr[i] = '0;
    test_reset();
    test_store_load();
    test_push_pop();
    test_wrap();
    test_io();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
